mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the accumulator CPU's control FSM; owns the 256x8 unified program/data RAM.
- Services instruction fetches (PC address), operand reads, and stores (operand address) issued by control.
- Provides a byte-serial program-load port used before run.
- Returns read data with a registered valid handshake, and exposes its state for debug.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W locations.
- DATA_W, 8, data/byte width.

Ports:
- clk  in  1  system clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- pc_addr  in  ADDR_W  instruction fetch address.
- opr_addr  in  ADDR_W  operand read/store address.
- fetch  in  1  instruction fetch request.
- rd_req  in  1  operand read request.
- wr_req  in  1  store request.
- wr_data  in  DATA_W  store data (accumulator).
- rd_data  out  DATA_W  read/fetch data, held until next read completes.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_is_fetch  out  1  qualifies rd_valid: 1 = fetch, 0 = operand read.
- wr_ack  out  1  one-cycle pulse: store committed.
- busy  out  1  high whenever state != IDLE.
- ld_en  in  1  program-load mode request (level).
- ld_valid  in  1  ld_byte valid this cycle.
- ld_byte  in  DATA_W  program byte.
- ld_ready  out  1  load byte accepted this cycle when ld_valid=1.
- ld_full  out  1  all DEPTH locations loaded; further bytes refused.
- ld_done  out  1  one-cycle pulse on leaving LOAD.
- STATE  out  3  current state encoding (debug).

Behaviour:
- Reset: state=IDLE; rd_data=0, rd_valid=0, rd_is_fetch=0, wr_ack=0, busy=0, ld_ready=0, ld_full=0, ld_done=0, load pointer=0. RAM contents are NOT cleared.
- States: IDLE=0, ACCESS=1, RESP=2, WRITE=3, LOAD=4. Encodings 5-7 are illegal and go to IDLE next edge.
- IDLE request priority (sampled at posedge): ld_en > wr_req > rd_req > fetch.
  - Only the winner is captured. Losers are dropped; the requester re-asserts after busy falls.
- Read/fetch:
  - IDLE edge: capture address (opr_addr for rd_req, pc_addr for fetch) and the source flag; go ACCESS.
  - ACCESS edge: rd_data <= mem[addr]; go RESP.
  - RESP cycle: rd_valid=1 for exactly one cycle; go IDLE.
  - Latency: request sampled at edge k, rd_valid high from edge k+2 to k+3.
- Store:
  - IDLE edge: capture opr_addr and wr_data; go WRITE.
  - WRITE edge: mem[addr] <= data; go IDLE. wr_ack=1 during the WRITE cycle.
  - A read of the same address issued after busy falls returns the new data.
- Load:
  - IDLE edge with ld_en=1: pointer <= 0, ld_full <= 0, go LOAD.
  - In LOAD: ld_ready = ~ld_full. Each edge with ld_valid & ld_ready writes mem[ptr] <= ld_byte and increments ptr.
  - When a write lands at ptr == DEPTH-1: ptr wraps to 0 and ld_full <= 1. Later bytes are not written (no overwrite).
  - Leave LOAD when ld_en=0 at an edge: go IDLE, ld_done=1 for the following cycle. A byte presented on that same edge is discarded.
  - fetch/rd_req/wr_req are ignored throughout LOAD.
- busy is combinational from state. All other outputs are registered.
- Address arithmetic is unsigned ADDR_W bits; no out-of-range case exists.
- Reset mid-operation (any state): outputs return to reset values next cycle. An in-flight store not yet at its WRITE edge is lost. A partially loaded program remains in RAM.

Decomposition:
- Shared package mem_pkg:
  - typedef enum logic [2:0] memstate_t {IDLE, ACCESS, RESP, WRITE, LOAD}.
  - localparams for the default ADDR_W/DATA_W.
- One sub-module, byte_ram: synchronous-write / synchronous-read single-port DEPTHxDATA_W array, no reset. The FSM and load pointer live in mem_responder.

Test Plan:
- Load sequence: ld_en=1, stream 0x04,0x00,0x01,0x10 with ld_valid; drop ld_en -> ld_done pulse once. Then fetch with pc_addr=0..3 -> rd_valid with rd_is_fetch=1, rd_data = 0x04,0x00,0x01,0x10, each exactly 2 edges after the request.
- Store then read: wr_req, opr_addr=0x80, wr_data=0xA5 -> wr_ack one cycle, busy 1 cycle. Then rd_req at 0x80 -> rd_data=0xA5, rd_is_fetch=0.
- Simultaneous wr_req, rd_req, fetch in IDLE -> only the store occurs (wr_ack). No rd_valid until rd_req is reasserted after busy falls.
- Load overflow: stream 260 bytes (value = index mod 256) -> ld_full after byte 255, ld_ready=0 afterward. mem[0]=0x00 and mem[255]=0xFF; bytes 256-259 are not written.
- Reset mid-load after 10 bytes -> outputs return to reset values, state IDLE. A subsequent fetch at address 5 returns the loaded byte 0x05.
- Requests during LOAD (fetch=1, wr_req=1) -> no rd_valid, no wr_ack, and the RAM target address is unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2,
    WRITE  = 3'd3,
    LOAD   = 3'd4
  } memstate_t;

endpackage

// File: rtl/byte_ram.sv
// Single-port RAM: synchronous write, synchronous read with enable, no reset.
module byte_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and read register; rdata holds between enabled reads.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates fetch/read/store/program-load onto one byte RAM.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] opr_addr,
  input  logic              fetch,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_is_fetch,
  output logic              wr_ack,
  output logic              busy,
  input  logic              ld_en,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_byte,
  output logic              ld_ready,
  output logic              ld_full,
  output logic              ld_done,
  output logic [2:0]        STATE
);

  memstate_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_fetch_q, src_fetch_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ld_full_q, ld_full_d;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_is_fetch_q, wr_ack_q, ld_ready_q, ld_done_q;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  byte_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state logic, request arbitration and RAM port steering.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    src_fetch_d = src_fetch_q;
    ptr_d       = ptr_q;
    ld_full_d   = ld_full_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = addr_q;
    ram_wdata   = data_q;
    case (state_q)
      IDLE: begin
        // Priority ld_en > wr_req > rd_req > fetch; losers are dropped.
        if (ld_en) begin
          ptr_d     = '0;
          ld_full_d = 1'b0;
          state_d   = LOAD;
        end else if (wr_req) begin
          addr_d  = opr_addr;
          data_d  = wr_data;
          state_d = WRITE;
        end else if (rd_req) begin
          addr_d      = opr_addr;
          src_fetch_d = 1'b0;
          state_d     = ACCESS;
        end else if (fetch) begin
          addr_d      = pc_addr;
          src_fetch_d = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        ram_re  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      WRITE: begin
        ram_we  = 1'b1;
        state_d = IDLE;
      end
      LOAD: begin
        ram_addr  = ptr_q;
        ram_wdata = ld_byte;
        // Leaving takes precedence: a byte offered on the exit edge is discarded.
        if (!ld_en) begin
          state_d = IDLE;
        end else if (ld_valid && !ld_full_q) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
          if (ptr_q == '1) begin
            ld_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      src_fetch_q   <= 1'b0;
      ptr_q         <= '0;
      ld_full_q     <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_is_fetch_q <= 1'b0;
      wr_ack_q      <= 1'b0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      src_fetch_q <= src_fetch_d;
      ptr_q       <= ptr_d;
      ld_full_q   <= ld_full_d;
      rd_valid_q  <= (state_q == RESP);
      if (state_q == RESP) begin
        rd_data_q     <= ram_rdata;
        rd_is_fetch_q <= src_fetch_q;
      end
      wr_ack_q   <= (state_d == WRITE);
      ld_ready_q <= (state_d == LOAD) && !ld_full_d;
      ld_done_q  <= (state_q == LOAD) && !ld_en;
    end
  end

  assign busy        = (state_q != IDLE);
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_is_fetch = rd_is_fetch_q;
  assign wr_ack      = wr_ack_q;
  assign ld_ready    = ld_ready_q;
  assign ld_full     = ld_full_q;
  assign ld_done     = ld_done_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a read-result scoreboard and a RAM model.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc_addr, opr_addr, wr_data, rd_data, ld_byte;
  logic       fetch, rd_req, wr_req, rd_valid, rd_is_fetch, wr_ack, busy;
  logic       ld_en, ld_valid, ld_ready, ld_full, ld_done;
  logic [2:0] STATE;

  typedef struct packed {
    logic       f;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[256];
  int         total = 0;
  int         bad = 0;

  mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .opr_addr    (opr_addr),
    .fetch       (fetch),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_is_fetch (rd_is_fetch),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .ld_en       (ld_en),
    .ld_valid    (ld_valid),
    .ld_byte     (ld_byte),
    .ld_ready    (ld_ready),
    .ld_full     (ld_full),
    .ld_done     (ld_done),
    .STATE       (STATE)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_is_fetch"}, 32'(rd_is_fetch), 0);
    chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 0);
    chk({tag, "_ld_full"}, 32'(ld_full), 0);
    chk({tag, "_ld_done"}, 32'(ld_done), 0);
    chk({tag, "_state"}, 32'(STATE), 0);
  endtask

  // Issue a read/fetch at a negedge; expect the pulse exactly two edges later.
  task automatic do_read(input logic isf, input logic [7:0] a);
    exp_t e;
    int   lat;
    if (isf) begin
      fetch   = 1'b1;
      pc_addr = a;
    end else begin
      rd_req   = 1'b1;
      opr_addr = a;
    end
    sb.push_back('{f: isf, d: model[a]});
    @(negedge clk);
    fetch  = 1'b0;
    rd_req = 1'b0;
    lat    = 0;
    while (!rd_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_valid_seen", 32'(rd_valid), 1);
    chk("rd_latency", 32'(lat), 2);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data", 32'(rd_data), 32'(e.d));
      chk("rd_is_fetch", 32'(rd_is_fetch), 32'(e.f));
    end
    @(negedge clk);
    chk("rd_valid_pulse", 32'(rd_valid), 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    wr_req   = 1'b1;
    opr_addr = a;
    wr_data  = d;
    model[a] = d;
    @(negedge clk);
    wr_req = 1'b0;
    chk("wr_ack_hi", 32'(wr_ack), 1);
    chk("wr_busy_hi", 32'(busy), 1);
    @(negedge clk);
    chk("wr_ack_lo", 32'(wr_ack), 0);
    chk("wr_busy_lo", 32'(busy), 0);
  endtask

  task automatic load_begin();
    ld_en = 1'b1;
    @(negedge clk);
    chk("ld_state", 32'(STATE), 4);
    chk("ld_ready_start", 32'(ld_ready), 1);
    chk("ld_busy", 32'(busy), 1);
    chk("ld_full_start", 32'(ld_full), 0);
  endtask

  task automatic load_byte(input logic [7:0] v);
    ld_valid = 1'b1;
    ld_byte  = v;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load_end();
    ld_en    = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("ld_done_hi", 32'(ld_done), 1);
    chk("ld_exit_state", 32'(STATE), 0);
    chk("ld_exit_ready", 32'(ld_ready), 0);
    @(negedge clk);
    chk("ld_done_lo", 32'(ld_done), 0);
  endtask

  initial begin
    logic [7:0] prog[4];
    logic [7:0] v;
    prog = '{8'h04, 8'h00, 8'h01, 8'h10};
    reset = 1'b1;
    pc_addr = '0; opr_addr = '0; wr_data = '0; ld_byte = '0;
    fetch = 1'b0; rd_req = 1'b0; wr_req = 1'b0; ld_en = 1'b0; ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Program load then fetch it back.
    load_begin();
    for (int i = 0; i < 4; i++) begin
      load_byte(prog[i]);
      model[i] = prog[i];
    end
    chk("ld_full_short", 32'(ld_full), 0);
    load_end();
    for (int i = 0; i < 4; i++) do_read(1'b1, 8'(i));

    // Store then read back.
    do_write(8'h80, 8'hA5);
    do_read(1'b0, 8'h80);

    // Simultaneous requests: the store wins, the read is dropped.
    wr_req = 1'b1; rd_req = 1'b1; fetch = 1'b1;
    opr_addr = 8'h40; wr_data = 8'h3C; pc_addr = 8'h00;
    model[8'h40] = 8'h3C;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0; fetch = 1'b0;
    chk("arb_wr_ack", 32'(wr_ack), 1);
    chk("arb_state", 32'(STATE), 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_no_rd_valid", 32'(rd_valid), 0);
    end
    do_read(1'b0, 8'h40);

    // Reset in the middle of a load; loaded bytes survive.
    load_begin();
    for (int i = 0; i < 10; i++) begin
      load_byte(8'(i));
      model[i] = 8'(i);
    end
    ld_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    do_read(1'b1, 8'h05);

    // Overflow: bytes past 255 carry a marker so a stray overwrite of 0..3 is visible.
    load_begin();
    for (int i = 0; i < 260; i++) begin
      chk("ld_ready_ovf", 32'(ld_ready), 32'(i < 256));
      v = (i < 256) ? 8'(i) : 8'hEE;
      load_byte(v);
      if (i < 256) model[i] = v;
      if (i == 255) begin
        chk("ld_full_set", 32'(ld_full), 1);
        chk("ld_ready_full", 32'(ld_ready), 0);
      end
    end
    chk("ld_full_hold", 32'(ld_full), 1);
    load_end();
    do_read(1'b1, 8'h00);
    do_read(1'b1, 8'hFF);
    do_read(1'b0, 8'h03);
    do_read(1'b0, 8'h80);

    // Requests during LOAD are ignored.
    load_begin();
    fetch = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    pc_addr = 8'h10; opr_addr = 8'h10; wr_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ldreq_rd_valid", 32'(rd_valid), 0);
      chk("ldreq_wr_ack", 32'(wr_ack), 0);
      chk("ldreq_state", 32'(STATE), 4);
    end
    fetch = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    load_end();
    do_read(1'b0, 8'h10);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
